// File: rtl/hazard_scoreboard.sv
// Register-level RAW/WAW hazard scoreboard with per-register latency countdowns.
// Define HAZARD_SCOREBOARD_FWD_EN when results with one cycle left can be forwarded.
module hazard_scoreboard #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned LAT_W  = 3,
  parameter int unsigned STAT_W = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [ADDR_W-1:0]    rs1,
  input  logic [ADDR_W-1:0]    rs2,
  input  logic                 rs1_used,
  input  logic                 rs2_used,
  input  logic                 issue_valid,
  input  logic                 issue_we,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic [LAT_W-1:0]     issue_lat,
  input  logic                 flush,
  output logic                 stall,
  output logic                 pc_write,
  output logic                 write_if_id,
  output logic                 bubble,
  output logic [2**ADDR_W-1:0] busy_mask,
  output logic [STAT_W-1:0]    stall_cnt
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

`ifdef HAZARD_SCOREBOARD_FWD_EN
  localparam logic [LAT_W-1:0] RawThresh = LAT_W'(1);
`else
  localparam logic [LAT_W-1:0] RawThresh = '0;
`endif

  localparam logic [STAT_W-1:0] StatMax = '1;

  logic [NumRegs-1:0][LAT_W-1:0] cnt_all;
  logic                          raw_rs1;
  logic                          raw_rs2;
  logic                          waw;
  logic                          accept;
  logic                          track;
  logic [STAT_W-1:0]             stall_cnt_q;
  logic [STAT_W-1:0]             stall_cnt_d;

  // Hazard detection and issue acceptance, all from current state.
  always_comb begin
    raw_rs1 = rs1_used && (rs1 != '0) && (cnt_all[rs1] > RawThresh);
    raw_rs2 = rs2_used && (rs2 != '0) && (cnt_all[rs2] > RawThresh);
    waw     = issue_we && (issue_rd != '0) && (cnt_all[issue_rd] > issue_lat);
    stall   = issue_valid && !flush && (raw_rs1 || raw_rs2 || waw);
    accept  = issue_valid && !stall && !flush;
    track   = accept && issue_we && (issue_rd != '0) && (issue_lat != '0);
  end

  assign pc_write    = ~stall;
  assign write_if_id = ~stall;
  assign bubble      = stall;

  // Register zero is hardwired and never tracked.
  assign cnt_all[0] = '0;

  for (genvar i = 1; i < NumRegs; i++) begin : g_cnt
    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    // A newly tracked write overrides the countdown of an older one.
    always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
        cnt_d = '0;
      end else if (track && (issue_rd == ADDR_W'(i))) begin
        cnt_d = issue_lat;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - LAT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_all[i] = cnt_q;
  end

  always_comb begin
    for (int unsigned j = 0; j < NumRegs; j++) begin
      busy_mask[j] = |cnt_all[j];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != StatMax)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// against a per-register remaining-latency model.
module tb_hazard_scoreboard;

  localparam int NREG = 32;
`ifdef HAZARD_SCOREBOARD_FWD_EN
  localparam int T = 1;
`else
  localparam int T = 0;
`endif

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [4:0]  rs1, rs2, issue_rd;
  logic        rs1_used, rs2_used, issue_valid, issue_we, flush;
  logic [2:0]  issue_lat;
  logic        stall, pc_write, write_if_id, bubble;
  logic [31:0] busy_mask;
  logic [15:0] stall_cnt;
  logic        b_stall, b_pc_write, b_write_if_id, b_bubble;
  logic [31:0] b_busy_mask;
  logic [1:0]  b_stall_cnt;

  int checks = 0;
  int failures = 0;
  int m_cnt[NREG];
  int m_stalls = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .arst_n(arst_n), .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used),
    .rs2_used(rs2_used), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .flush(flush), .stall(stall),
    .pc_write(pc_write), .write_if_id(write_if_id), .bubble(bubble),
    .busy_mask(busy_mask), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.ADDR_W(5), .LAT_W(3), .STAT_W(2)) dut_sat (
    .clk(clk), .arst_n(arst_n), .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used),
    .rs2_used(rs2_used), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .flush(flush), .stall(b_stall),
    .pc_write(b_pc_write), .write_if_id(b_write_if_id), .bubble(b_bubble),
    .busy_mask(b_busy_mask), .stall_cnt(b_stall_cnt)
  );

  // Reference: m_cnt[r] is the number of cycles until register r's pending result is ready.
  function automatic bit m_stall();
    bit raw1, raw2, w;
    raw1 = rs1_used && rs1 != 0 && m_cnt[rs1] > T;
    raw2 = rs2_used && rs2 != 0 && m_cnt[rs2] > T;
    w    = issue_we && issue_rd != 0 && m_cnt[issue_rd] > int'(issue_lat);
    return issue_valid && !flush && (raw1 || raw2 || w);
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    for (int i = 0; i < NREG; i++) m[i] = (m_cnt[i] > 0);
    return m;
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
    m_stalls = 0;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                       input logic [2:0] lat, input logic [4:0] a1, input logic u1,
                       input logic [4:0] a2, input logic u2, input logic fl);
    issue_valid = v; issue_we = we; issue_rd = rd; issue_lat = lat;
    rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Advance the model by one clock, then move to the next falling edge.
  task automatic tick();
    bit st;
    bit acc;
    st  = m_stall();
    acc = issue_valid && !st && !flush;
    if (st) m_stalls++;
    for (int i = 0; i < NREG; i++) begin
      if (flush) m_cnt[i] = 0;
      else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
    end
    if (acc && !flush && issue_we && issue_rd != 0 && issue_lat != 0)
      m_cnt[issue_rd] = int'(issue_lat);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset();
    idle();
    #2;
    checks++;
    if (stall !== 1'b0 || bubble !== 1'b0 || pc_write !== 1'b1 || write_if_id !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctrl: stall=%b bubble=%b pc_write=%b write_if_id=%b, need 0 0 1 1",
               stall, bubble, pc_write, write_if_id);
    end
    checks++;
    if (busy_mask !== 32'd0 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: busy_mask=%h stall_cnt=%0d, need 0 0", busy_mask, stall_cnt);
    end
    @(negedge clk);
    arst_n = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if (busy_mask !== 32'd0 || stall_cnt !== 16'd0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: busy_mask=%h stall_cnt=%0d stall=%b, need 0 0 0",
               busy_mask, stall_cnt, stall);
    end
  endtask

  task automatic test_load_use();
    int nst = 0;
    drive(1'b1, 1'b1, 5'd5, 3'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL load_use_issue: stall=%b, need 0", stall);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 5'd0, 3'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if (stall !== m_stall()) begin
        failures++;
        $display("FAIL load_use_cycle%0d: stall=%b, need %b", c, stall, m_stall());
      end
      if (stall === 1'b1) nst++;
      tick();
    end
    checks++;
    if (nst != 2 - T || stall_cnt !== 16'(2 - T)) begin
      failures++;
      $display("FAIL load_use_count: stall_cycles=%0d stall_cnt=%0d, need %0d", nst,
               stall_cnt, 2 - T);
    end
  endtask

  task automatic test_reg_zero();
    drive(1'b1, 1'b1, 5'd0, 3'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0 || busy_mask !== 32'd0) begin
      failures++;
      $display("FAIL reg_zero: stall=%b busy_mask=%h, need 0 0", stall, busy_mask);
    end
    tick();
  endtask

  task automatic test_waw();
    int nst = 0;
    drain();
    drive(1'b1, 1'b1, 5'd7, 3'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 8; c++) begin
      bit s;
      drive(1'b1, 1'b1, 5'd7, 3'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      s = stall;
      checks++;
      if (stall !== m_stall()) begin
        failures++;
        $display("FAIL waw_cycle%0d: stall=%b, need %b", c, stall, m_stall());
      end
      if (s) nst++;
      tick();
      if (!s) break;
    end
    idle();
    #1;
    checks++;
    if (nst != 3 || busy_mask[7] !== 1'b1) begin
      failures++;
      $display("FAIL waw_accept: stall_cycles=%0d busy7=%b, need 3 1", nst, busy_mask[7]);
    end
    tick();
    checks++;
    if (busy_mask[7] !== 1'b0) begin
      failures++;
      $display("FAIL waw_reload: busy7=%b, need 0", busy_mask[7]);
    end
  endtask

  task automatic test_flush();
    drain();
    drive(1'b1, 1'b1, 5'd3, 3'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5'd4, 3'd5, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0 || busy_mask !== 32'h8) begin
      failures++;
      $display("FAIL flush_stall: stall=%b busy_mask=%h, need 0 00000008", stall, busy_mask);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy_mask !== 32'd0) begin
      failures++;
      $display("FAIL flush_clear: busy_mask=%h, need 0", busy_mask);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 5'd9, 3'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    arst_n = 1'b0;
    #1;
    checks++;
    if (busy_mask !== 32'd0 || stall_cnt !== 16'd0 || b_stall_cnt !== 2'd0) begin
      failures++;
      $display("FAIL async_reset: busy_mask=%h stall_cnt=%0d sat_cnt=%0d, need 0 0 0",
               busy_mask, stall_cnt, b_stall_cnt);
    end
    m_reset();
    #1;
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b1, 5'd4, 3'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 3'd0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) tick();
    #1;
    checks++;
    if (b_stall_cnt !== 2'd3 || stall_cnt !== 16'd6) begin
      failures++;
      $display("FAIL saturation: sat_cnt=%0d stall_cnt=%0d, need 3 6", b_stall_cnt, stall_cnt);
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bit es;
      drive(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 5'($urandom_range(7)),
            3'($urandom_range(7)), 5'($urandom_range(7)), 1'($urandom_range(1)),
            5'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(15) == 0));
      #1;
      es = m_stall();
      checks++;
      if (stall !== es || bubble !== es || pc_write !== !es || write_if_id !== !es) begin
        failures++;
        $display("FAIL rand_ctrl@%0d: stall=%b bubble=%b pc_write=%b write_if_id=%b, need stall %b",
                 c, stall, bubble, pc_write, write_if_id, es);
      end
      checks++;
      if (busy_mask !== m_mask() || b_busy_mask !== m_mask()) begin
        failures++;
        $display("FAIL rand_busy@%0d: busy_mask=%h sat_busy=%h, need %h", c, busy_mask,
                 b_busy_mask, m_mask());
      end
      checks++;
      if (stall_cnt !== 16'(sat(m_stalls, 65535)) || b_stall_cnt !== 2'(sat(m_stalls, 3))) begin
        failures++;
        $display("FAIL rand_stat@%0d: stall_cnt=%0d sat_cnt=%0d, need %0d %0d", c, stall_cnt,
                 b_stall_cnt, sat(m_stalls, 65535), sat(m_stalls, 3));
      end
      tick();
    end
  endtask

  initial begin
    idle();
    m_reset();
    test_reset();
    test_load_use();
    test_reg_zero();
    test_waw();
    test_flush();
    test_async_reset();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
